// File: rtl/bullet_pool.sv
// Multi-slot projectile manager: spawns, flies and retires up to NUM_BULLETS bullets per frame.
// Optional build macro BULLET_POOL_AUTOFIRE_EN makes a held fire key re-fire every COOLDOWN+1 frames.
module bullet_pool #(
  parameter int NUM_BULLETS = 4,
  parameter int STEP        = 2,
  parameter int SIZE        = 4,
  parameter int COOLDOWN    = 8,
  parameter int FIRE_KEY    = 88,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479
) (
  input  logic                      frame_clk,
  input  logic                      Reset_n,
  input  logic [7:0]                keycode,
  input  logic [1:0]                dir,
  input  logic [9:0]                BallX,
  input  logic [9:0]                BallY,
  input  logic [9:0]                BallS,
  input  logic [NUM_BULLETS-1:0]    hit_clr,
  output logic [10*NUM_BULLETS-1:0] BulletX,
  output logic [10*NUM_BULLETS-1:0] BulletY,
  output logic [9:0]                BulletS,
  output logic [NUM_BULLETS-1:0]    bullet_on,
  output logic                      fire_pulse,
  output logic                      pool_full
);

  localparam int          CD_W   = $clog2(COOLDOWN + 2);
  localparam logic [10:0] MARGIN = 11'(SIZE + STEP);
  localparam logic [9:0]  STEP_V = 10'(STEP);

  typedef enum logic {IDLE = 1'b0, FLY = 1'b1} slot_state_t;

  slot_state_t            state_q [NUM_BULLETS];
  slot_state_t            state_d [NUM_BULLETS];
  logic [9:0]             pos_x   [NUM_BULLETS];
  logic [9:0]             pos_y   [NUM_BULLETS];
  logic [1:0]             dir_q   [NUM_BULLETS];
  logic [CD_W-1:0]        cooldown;
  logic                   key_hit;
  logic                   fire_req;
  logic                   spawn;
  logic [NUM_BULLETS-1:0] free_mask;
  logic [NUM_BULLETS-1:0] spawn_oh;
  logic [NUM_BULLETS-1:0] edge_hit;
  logic [19:0]            spawn_xy;

  // Edge test uses 11-bit unsigned math so X+margin cannot wrap near the right edge.
  function automatic logic at_edge(input logic [1:0] d, input logic [9:0] x, input logic [9:0] y);
    logic [10:0] xe;
    logic [10:0] ye;
    xe = {1'b0, x};
    ye = {1'b0, y};
    case (d)
      2'd0:    at_edge = (xe < MARGIN);
      2'd1:    at_edge = (xe + MARGIN > 11'(X_MAX));
      2'd2:    at_edge = (ye < MARGIN);
      default: at_edge = (ye + MARGIN > 11'(Y_MAX));
    endcase
  endfunction

  function automatic logic [19:0] spawn_pos(input logic [1:0] d, input logic [9:0] bx,
                                            input logic [9:0] by, input logic [9:0] bs);
    case (d)
      2'd0:    spawn_pos = {bx - bs, by};
      2'd1:    spawn_pos = {bx + bs, by};
      2'd2:    spawn_pos = {bx, by - bs};
      default: spawn_pos = {bx, by + bs};
    endcase
  endfunction

  assign key_hit = (keycode == 8'(FIRE_KEY));

`ifdef BULLET_POOL_AUTOFIRE_EN
  assign fire_req = key_hit;
`else
  logic key_prev;
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) key_prev <= 1'b0;
    else          key_prev <= key_hit;
  end
  assign fire_req = key_hit & ~key_prev;
`endif

  // Allocation sees the pre-clear mask, so a slot retired this frame is reused next frame at earliest.
  assign free_mask = ~bullet_on;
  assign spawn     = fire_req && (cooldown == '0) && (|free_mask);
  assign spawn_oh  = spawn ? (free_mask & (~free_mask + NUM_BULLETS'(1))) : '0;
  assign spawn_xy  = spawn_pos(dir, BallX, BallY, BallS);

  always_comb begin
    edge_hit = '0;
    for (int i = 0; i < NUM_BULLETS; i++)
      edge_hit[i] = at_edge(dir_q[i], pos_x[i], pos_y[i]);
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_BULLETS; i++) state_q[i] <= IDLE;
    end else begin
      for (int i = 0; i < NUM_BULLETS; i++) state_q[i] <= state_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BULLETS; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE:    if (spawn_oh[i]) state_d[i] = FLY;
        default: if (hit_clr[i] || edge_hit[i]) state_d[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    bullet_on = '0;
    BulletX   = '0;
    BulletY   = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      bullet_on[i]       = (state_q[i] == FLY);
      BulletX[10*i +: 10] = pos_x[i];
      BulletY[10*i +: 10] = pos_y[i];
    end
    pool_full = &bullet_on;
    BulletS   = 10'(SIZE);
  end

  // Frame update: spawn loads ship-relative position, flying slots step unless retiring.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
        dir_q[i] <= '0;
      end
      cooldown   <= '0;
      fire_pulse <= 1'b0;
    end else begin
      fire_pulse <= spawn;
      if (spawn)                 cooldown <= CD_W'(COOLDOWN);
      else if (cooldown != '0)   cooldown <= cooldown - 1'b1;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        if (spawn_oh[i]) begin
          pos_x[i] <= spawn_xy[19:10];
          pos_y[i] <= spawn_xy[9:0];
          dir_q[i] <= dir;
        end else if (state_q[i] == FLY && !hit_clr[i] && !edge_hit[i]) begin
          case (dir_q[i])
            2'd0:    pos_x[i] <= pos_x[i] - STEP_V;
            2'd1:    pos_x[i] <= pos_x[i] + STEP_V;
            2'd2:    pos_y[i] <= pos_y[i] - STEP_V;
            default: pos_y[i] <= pos_y[i] + STEP_V;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_bullet_pool.sv
// Scoreboard bench for bullet_pool in its default (edge-triggered fire) build.
module tb_bullet_pool;
  localparam int N = 4;

  logic          frame_clk = 1'b0;
  logic          Reset_n   = 1'b0;
  logic [7:0]    keycode   = '0;
  logic [1:0]    dir       = '0;
  logic [9:0]    BallX     = '0;
  logic [9:0]    BallY     = '0;
  logic [9:0]    BallS     = '0;
  logic [N-1:0]  hit_clr   = '0;
  logic [10*N-1:0] BulletX;
  logic [10*N-1:0] BulletY;
  logic [9:0]    BulletS;
  logic [N-1:0]  bullet_on;
  logic          fire_pulse;
  logic          pool_full;

  bullet_pool dut (
    .frame_clk (frame_clk), .Reset_n (Reset_n), .keycode (keycode), .dir (dir),
    .BallX (BallX), .BallY (BallY), .BallS (BallS), .hit_clr (hit_clr),
    .BulletX (BulletX), .BulletY (BulletY), .BulletS (BulletS),
    .bullet_on (bullet_on), .fire_pulse (fire_pulse), .pool_full (pool_full)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct { string name; logic [63:0] val; } exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic test_reset();
    logic [63:0] obs[$];
    exp_t e;
    Reset_n = 1'b0;
    #3;
    sb.push_back('{name:"rst_on",   val:64'(0)});
    sb.push_back('{name:"rst_fire", val:64'(0)});
    sb.push_back('{name:"rst_x",    val:64'(0)});
    sb.push_back('{name:"rst_y",    val:64'(0)});
    sb.push_back('{name:"rst_s",    val:64'(4)});
    sb.push_back('{name:"rst_full", val:64'(0)});
    obs = '{64'(bullet_on), 64'(fire_pulse), 64'(BulletX), 64'(BulletY), 64'(BulletS), 64'(pool_full)};
    foreach (obs[j]) begin
      e = sb.pop_front();
      n_checks++;
      if (obs[j] !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, obs[j], e.val);
      else n_pass++;
    end
    tick();
    @(negedge frame_clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_spawn_left();
    logic [63:0] obs[$];
    exp_t e;
    BallX = 10'd320; BallY = 10'd240; BallS = 10'd8; dir = 2'd0; keycode = 8'd88;
    sb.push_back('{name:"spawn_on",   val:64'(4'b0001)});
    sb.push_back('{name:"spawn_fire", val:64'(1)});
    sb.push_back('{name:"spawn_x",    val:64'(312)});
    sb.push_back('{name:"spawn_y",    val:64'(240)});
    tick();
    obs = '{64'(bullet_on), 64'(fire_pulse), 64'(BulletX[9:0]), 64'(BulletY[9:0])};
    foreach (obs[j]) begin
      e = sb.pop_front();
      n_checks++;
      if (obs[j] !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, obs[j], e.val);
      else n_pass++;
    end
    keycode = 8'd0;
    dir = 2'd1;
    for (int k = 1; k <= 154; k++) begin
      sb.push_back('{name:"fly_x",    val:64'(312 - 2 * k)});
      sb.push_back('{name:"fly_fire", val:64'(0)});
      sb.push_back('{name:"fly_on",   val:64'(4'b0001)});
      tick();
      obs = '{64'(BulletX[9:0]), 64'(fire_pulse), 64'(bullet_on)};
      foreach (obs[j]) begin
        e = sb.pop_front();
        n_checks++;
        if (obs[j] !== e.val) $display("FAIL %s k=%0d: got %0d expected %0d", e.name, k, obs[j], e.val);
        else n_pass++;
      end
    end
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{name:"retire_on", val:64'(0)});
      sb.push_back('{name:"retire_x",  val:64'(4)});
      tick();
      obs = '{64'(bullet_on), 64'(BulletX[9:0])};
      foreach (obs[j]) begin
        e = sb.pop_front();
        n_checks++;
        if (obs[j] !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, obs[j], e.val);
        else n_pass++;
      end
    end
  endtask

  task automatic test_hold_key();
    logic [63:0] obs[$];
    exp_t e;
    int spawns;
    spawns = 0;
    dir = 2'd0; keycode = 8'd88;
    sb.push_back('{name:"hold_spawns", val:64'(1)});
    sb.push_back('{name:"hold_on",     val:64'(4'b0001)});
    sb.push_back('{name:"hold_x",      val:64'(234)});
    for (int k = 0; k < 40; k++) begin
      tick();
      if (fire_pulse === 1'b1) spawns++;
    end
    obs = '{64'(spawns), 64'(bullet_on), 64'(BulletX[9:0])};
    foreach (obs[j]) begin
      e = sb.pop_front();
      n_checks++;
      if (obs[j] !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, obs[j], e.val);
      else n_pass++;
    end
    keycode = 8'd0; hit_clr = 4'b0001;
    sb.push_back('{name:"hit_on", val:64'(0)});
    sb.push_back('{name:"hit_x",  val:64'(234)});
    tick();
    obs = '{64'(bullet_on), 64'(BulletX[9:0])};
    foreach (obs[j]) begin
      e = sb.pop_front();
      n_checks++;
      if (obs[j] !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, obs[j], e.val);
      else n_pass++;
    end
    hit_clr = '0;
  endtask

  task automatic test_pool_full();
    logic [63:0] obs[$];
    exp_t e;
    dir = 2'd1;
    for (int s = 0; s < N; s++) begin
      keycode = 8'd88;
      sb.push_back('{name:"fill_on",   val:64'((1 << (s + 1)) - 1)});
      sb.push_back('{name:"fill_fire", val:64'(1)});
      sb.push_back('{name:"fill_x",    val:64'(328)});
      tick();
      obs = '{64'(bullet_on), 64'(fire_pulse), 64'(BulletX[10*s +: 10])};
      foreach (obs[j]) begin
        e = sb.pop_front();
        n_checks++;
        if (obs[j] !== e.val) $display("FAIL %s s=%0d: got %0d expected %0d", e.name, s, obs[j], e.val);
        else n_pass++;
      end
      keycode = 8'd0;
      repeat (9) tick();
    end
    // dropped press, then hit on slot 2 coinciding with a press, then reallocation
    keycode = 8'd88;
    sb.push_back('{name:"full_flag", val:64'(1)});
    sb.push_back('{name:"drop_on",   val:64'(4'b1111)});
    sb.push_back('{name:"drop_fire", val:64'(0)});
    obs = '{64'(pool_full)};
    tick();
    obs.push_back(64'(bullet_on));
    obs.push_back(64'(fire_pulse));
    keycode = 8'd0;
    repeat (9) tick();
    keycode = 8'd88; hit_clr = 4'b0100;
    sb.push_back('{name:"hitpress_on",   val:64'(4'b1011)});
    sb.push_back('{name:"hitpress_fire", val:64'(0)});
    sb.push_back('{name:"hitpress_full", val:64'(0)});
    tick();
    obs.push_back(64'(bullet_on));
    obs.push_back(64'(fire_pulse));
    obs.push_back(64'(pool_full));
    hit_clr = '0; keycode = 8'd0;
    sb.push_back('{name:"release_on", val:64'(4'b1011)});
    tick();
    obs.push_back(64'(bullet_on));
    keycode = 8'd88;
    sb.push_back('{name:"realloc_on",   val:64'(4'b1111)});
    sb.push_back('{name:"realloc_fire", val:64'(1)});
    sb.push_back('{name:"realloc_x",    val:64'(328)});
    tick();
    obs.push_back(64'(bullet_on));
    obs.push_back(64'(fire_pulse));
    obs.push_back(64'(BulletX[29:20]));
    keycode = 8'd0; dir = 2'd2;
    sb.push_back('{name:"latched_x", val:64'(330)});
    sb.push_back('{name:"latched_y", val:64'(240)});
    tick();
    obs.push_back(64'(BulletX[29:20]));
    obs.push_back(64'(BulletY[29:20]));
    foreach (obs[j]) begin
      e = sb.pop_front();
      n_checks++;
      if (obs[j] !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, obs[j], e.val);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midflight_and_down();
    logic [63:0] obs[$];
    exp_t e;
    hit_clr = 4'b1000;
    sb.push_back('{name:"pre_rst_on", val:64'(4'b0111)});
    tick();
    obs = '{64'(bullet_on)};
    hit_clr = '0;
    @(negedge frame_clk);
    #2;
    Reset_n = 1'b0; keycode = 8'd88;
    #1;
    sb.push_back('{name:"async_on", val:64'(0)});
    sb.push_back('{name:"async_x",  val:64'(0)});
    sb.push_back('{name:"async_y",  val:64'(0)});
    obs.push_back(64'(bullet_on));
    obs.push_back(64'(BulletX));
    obs.push_back(64'(BulletY));
    BallX = 10'd320; BallY = 10'd470; BallS = 10'd4; dir = 2'd3;
    @(negedge frame_clk);
    Reset_n = 1'b1;
    sb.push_back('{name:"down_on",   val:64'(4'b0001)});
    sb.push_back('{name:"down_fire", val:64'(1)});
    sb.push_back('{name:"down_x",    val:64'(320)});
    sb.push_back('{name:"down_y",    val:64'(474)});
    tick();
    obs.push_back(64'(bullet_on));
    obs.push_back(64'(fire_pulse));
    obs.push_back(64'(BulletX[9:0]));
    obs.push_back(64'(BulletY[9:0]));
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{name:"down_ret_on",   val:64'(0)});
      sb.push_back('{name:"down_ret_y",    val:64'(474)});
      sb.push_back('{name:"down_ret_fire", val:64'(0)});
      tick();
      obs.push_back(64'(bullet_on));
      obs.push_back(64'(BulletY[9:0]));
      obs.push_back(64'(fire_pulse));
    end
    keycode = 8'd0;
    foreach (obs[j]) begin
      e = sb.pop_front();
      n_checks++;
      if (obs[j] !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, obs[j], e.val);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_spawn_left();
    test_hold_key();
    test_pool_full();
    test_reset_midflight_and_down();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench still running at %0t, expected completion", $time);
    $fatal(1, "bench timeout");
  end

endmodule
